commit_arb: RTL and testbench
=============================

COMMIT_ARB -- requirements
Module: commit_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of execution-unit result channels (1..8).
REQ-002 SHALL have parameter NUM_WP, default 2, number of register-file write ports (1..NUM_CH).
REQ-003 SHALL have parameter DATA_W, default 64, result data width.
REQ-004 SHALL have parameter RN_W, default 6, register-number width; rn 0 means no destination.
REQ-005 SHALL have ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ch_valid  input  NUM_CH  per-channel result valid.
- ch_rn  input  NUM_CH*RN_W  per-channel destination register; channel i at bits [i*RN_W +: RN_W].
- ch_data  input  NUM_CH*DATA_W  per-channel result; channel i at bits [i*DATA_W +: DATA_W].
- ch_stall  output  NUM_CH  per-channel backpressure.
- wr_en  output  NUM_WP  write-port enable.
- wr_rn  output  NUM_WP*RN_W  write-port register number; also serves as the scheduler "finished" notification.
- wr_data  output  NUM_WP*DATA_W  write-port data.
- retire_count  output  32  count of committed writes, saturating.

Function
REQ-006 SHALL hold one slot per channel: full flag, rn, data.
REQ-007 Channel i input SHALL be accepted on a cycle with ch_valid[i]=1 and ch_stall[i]=0.
- rn != 0: captured into slot i at the next edge.
- rn == 0: discarded; slot unchanged.
REQ-008 ch_stall[i] SHALL be combinational: slot i full AND slot i not granted this cycle.
- A granted full slot accepts a new entry in the same cycle.
REQ-009 Grant SHALL consider only full slots, scanned round-robin from pointer rr_ptr (wrapping NUM_CH-1 -> 0).
- Up to NUM_WP slots are granted; the k-th granted slot in scan order drives write port k.
REQ-010 A full slot SHALL NOT be granted if its rn equals the rn of a slot granted earlier in the same scan.
- It waits, which preserves a single writer per rn per cycle.
REQ-011 Granted slots SHALL clear at the next edge unless refilled per REQ-008.
REQ-012 Write ports SHALL be registered.
- Port k with a grant: wr_en[k]=1 and wr_rn/wr_data from that slot.
- Unused port: wr_en[k]=0, wr_rn[k]=0, wr_data[k]=0.
REQ-013 Latency SHALL be: input accepted in cycle N, written to slot at edge N+1, wr_en visible in cycle N+2 with no contention.
REQ-014 If any grant occurred, rr_ptr SHALL advance to (last granted channel + 1) mod NUM_CH; otherwise it SHALL hold.
REQ-015 retire_count SHALL add popcount(grants) each cycle and saturate at 32'hFFFFFFFF.
REQ-016 Channels SHALL be independent: stall on one channel SHALL NOT affect acceptance on another.

Reset
REQ-017 Asynchronous assertion of rst_n=0 SHALL clear the following, effective immediately:
- all slots (empty)
- rr_ptr=0
- wr_en=0, wr_rn=0, wr_data=0
- retire_count=0
- ch_stall=0, since no slot is full.
REQ-018 Results in flight at reset SHALL be lost.
REQ-019 The first acceptance SHALL occur on the first rising edge after deassertion.

Verification
REQ-020 Single result, NUM_CH=5, NUM_WP=2: ch_valid[2]=1, rn=7, data=64'hDEAD for 1 cycle (N) -> wr_en[0]=1, wr_rn[0]=7, wr_data[0]=64'hDEAD in cycle N+2; wr_en[1]=0; retire_count=1.
REQ-021 Contention, NUM_WP=1: channels 0..4 valid with rn 1..5, same cycle, held valid until accepted ->
- one write per cycle over 5 consecutive cycles, order 0,1,2,3,4;
- ch_stall[i] high while slot i waits;
- no result lost or duplicated.
REQ-022 Same-rn conflict, NUM_WP=2: channels 1 and 3 both rn=9, data A then B, same cycle, rr_ptr=0 ->
- cycle X: port 0 writes channel 1 data A, port 1 idle;
- cycle X+1: channel 3 data B.
REQ-023 rn=0 discard: ch_valid[4]=1, rn=0 -> ch_stall[4] never asserts, no wr_en, retire_count unchanged.
REQ-024 Reset mid-operation: three slots full, then rst_n=0 for 1 cycle (asynchronous) ->
- wr_en=0 and ch_stall=0 immediately;
- retire_count=0;
- no pre-reset result written after release.
REQ-025 Saturation: preload retire_count to 32'hFFFFFFFE via forced state, then commit 2 writes in one cycle -> retire_count=32'hFFFFFFFF and holds.

Source files
------------

// File: rtl/commit_arb_if.sv
// Result-channel and register-file write-port bundle for commit_arb.
// The master side produces results; the slave side is the arbiter.
interface commit_arb_if #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned NUM_WP = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RN_W   = 6
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*RN_W-1:0]   ch_rn;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_stall;
    logic [NUM_WP-1:0]        wr_en;
    logic [NUM_WP*RN_W-1:0]   wr_rn;
    logic [NUM_WP*DATA_W-1:0] wr_data;
    logic [31:0]              retire_count;

    modport master (
        output ch_valid, ch_rn, ch_data,
        input  ch_stall, wr_en, wr_rn, wr_data, retire_count
    );

    modport slave (
        input  ch_valid, ch_rn, ch_data,
        output ch_stall, wr_en, wr_rn, wr_data, retire_count
    );
endinterface

// File: rtl/commit_arb.sv
// Result commit arbiter: one holding slot per execution channel, round-robin grant of up to
// NUM_WP slots per cycle onto registered write ports, never two writers to the same rn.
module commit_arb #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned NUM_WP = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RN_W   = 6
) (
    input logic         clk,
    input logic         rst_n,
    commit_arb_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_WP + 1);

    logic [NUM_CH-1:0] slot_full_q, slot_full_d;
    logic [RN_W-1:0]   slot_rn_q   [NUM_CH];
    logic [RN_W-1:0]   slot_rn_d   [NUM_CH];
    logic [DATA_W-1:0] slot_data_q [NUM_CH];
    logic [DATA_W-1:0] slot_data_d [NUM_CH];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_WP-1:0] wr_en_q, wr_en_d;
    logic [RN_W-1:0]   wr_rn_q   [NUM_WP];
    logic [RN_W-1:0]   wr_rn_d   [NUM_WP];
    logic [DATA_W-1:0] wr_data_q [NUM_WP];
    logic [DATA_W-1:0] wr_data_d [NUM_WP];
    logic [31:0]       retire_q, retire_d;
    logic [32:0]       retire_sum;

    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0]  grant_cnt;
    logic [PTR_W-1:0]  last_ch;
    logic [PTR_W-1:0]  scan_idx;
    logic              conflict;
    logic [PTR_W-1:0]  port_sel [NUM_WP];
    logic [NUM_WP-1:0] port_vld;

    // Round-robin scan; a slot whose rn matches an earlier grant this cycle waits.
    always_comb begin
        grant     = '0;
        port_vld  = '0;
        grant_cnt = '0;
        last_ch   = rr_ptr_q;
        conflict  = 1'b0;
        scan_idx  = rr_ptr_q;
        for (int p = 0; p < NUM_WP; p++) port_sel[p] = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (slot_full_q[scan_idx] && (32'(grant_cnt) < NUM_WP)) begin
                conflict = 1'b0;
                for (int j = 0; j < NUM_CH; j++) begin
                    if (grant[j] && (slot_rn_q[j] == slot_rn_q[scan_idx])) conflict = 1'b1;
                end
                if (!conflict) begin
                    grant[scan_idx] = 1'b1;
                    for (int p = 0; p < NUM_WP; p++) begin
                        if (32'(grant_cnt) == p) begin
                            port_sel[p] = scan_idx;
                            port_vld[p] = 1'b1;
                        end
                    end
                    last_ch   = scan_idx;
                    grant_cnt = grant_cnt + CNT_W'(1);
                end
            end
            scan_idx = (32'(scan_idx) == NUM_CH - 1) ? '0 : scan_idx + PTR_W'(1);
        end
    end

    assign stall  = slot_full_q & ~grant;
    assign accept = bus.ch_valid & ~stall;

    // A granted slot drains and may refill in the same cycle; rn 0 results are dropped.
    always_comb begin
        slot_full_d = slot_full_q;
        slot_rn_d   = slot_rn_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) slot_full_d[i] = 1'b0;
            if (accept[i] && (bus.ch_rn[i*RN_W +: RN_W] != '0)) begin
                slot_full_d[i] = 1'b1;
                slot_rn_d[i]   = bus.ch_rn[i*RN_W +: RN_W];
                slot_data_d[i] = bus.ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_en_d = port_vld;
        for (int p = 0; p < NUM_WP; p++) begin
            wr_rn_d[p]   = port_vld[p] ? slot_rn_q[port_sel[p]] : '0;
            wr_data_d[p] = port_vld[p] ? slot_data_q[port_sel[p]] : '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (|grant) rr_ptr_d = (32'(last_ch) == NUM_CH - 1) ? '0 : last_ch + PTR_W'(1);
        retire_sum = {1'b0, retire_q} + 33'(grant_cnt);
        retire_d   = retire_sum[32] ? 32'hFFFF_FFFF : retire_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full_q <= '0;
            rr_ptr_q    <= '0;
            wr_en_q     <= '0;
            retire_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_rn_q[i]   <= '0;
                slot_data_q[i] <= '0;
            end
            for (int p = 0; p < NUM_WP; p++) begin
                wr_rn_q[p]   <= '0;
                wr_data_q[p] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            slot_rn_q   <= slot_rn_d;
            slot_data_q <= slot_data_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_rn_q     <= wr_rn_d;
            wr_data_q   <= wr_data_d;
            retire_q    <= retire_d;
        end
    end

    assign bus.ch_stall     = stall;
    assign bus.wr_en        = wr_en_q;
    assign bus.retire_count = retire_q;

    for (genvar p = 0; p < NUM_WP; p++) begin : g_port
        assign bus.wr_rn[p*RN_W +: RN_W]       = wr_rn_q[p];
        assign bus.wr_data[p*DATA_W +: DATA_W] = wr_data_q[p];
    end
endmodule

// File: tb/tb_commit_arb.sv
// Directed bench for commit_arb: a 2-port instance (a) and a 1-port instance (b)
// share clock and reset; expected values are hand-computed constants.
module tb_commit_arb;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    commit_arb_if #(.NUM_CH(5), .NUM_WP(2), .DATA_W(64), .RN_W(6)) bus_a ();
    commit_arb_if #(.NUM_CH(5), .NUM_WP(1), .DATA_W(64), .RN_W(6)) bus_b ();

    commit_arb #(.NUM_CH(5), .NUM_WP(2), .DATA_W(64), .RN_W(6)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    commit_arb #(.NUM_CH(5), .NUM_WP(1), .DATA_W(64), .RN_W(6)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_a();
        bus_a.ch_valid = '0;
        bus_a.ch_rn    = '0;
        bus_a.ch_data  = '0;
    endtask

    task automatic clear_b();
        bus_b.ch_valid = '0;
        bus_b.ch_rn    = '0;
        bus_b.ch_data  = '0;
    endtask

    task automatic set_a(input int ch, input logic [5:0] rn, input logic [63:0] data);
        bus_a.ch_valid[ch]       = 1'b1;
        bus_a.ch_rn[ch*6 +: 6]   = rn;
        bus_a.ch_data[ch*64 +: 64] = data;
    endtask

    task automatic set_b(input int ch, input logic [5:0] rn, input logic [63:0] data);
        bus_b.ch_valid[ch]       = 1'b1;
        bus_b.ch_rn[ch*6 +: 6]   = rn;
        bus_b.ch_data[ch*64 +: 64] = data;
    endtask

    // Leaves the bench at a falling edge with reset released, ready to drive.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_a();
        clear_b();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        clear_a();
        clear_b();
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_stall_a", 64'(bus_a.ch_stall), 64'h0);
        check("rst_wren_a", 64'(bus_a.wr_en), 64'h0);
        check("rst_wrrn_a", 64'(bus_a.wr_rn), 64'h0);
        check("rst_retire_a", 64'(bus_a.retire_count), 64'h0);
        check("rst_stall_b", 64'(bus_b.ch_stall), 64'h0);
        check("rst_wren_b", 64'(bus_b.wr_en), 64'h0);
        rst_n = 1'b1;

        // Single result, two-cycle latency, accepted on first edge after release
        set_a(2, 6'd7, 64'hDEAD);
        @(negedge clk);
        clear_a();
        check("single_stall", 64'(bus_a.ch_stall), 64'h0);
        check("single_wren_early", 64'(bus_a.wr_en), 64'h0);
        @(negedge clk);
        check("single_wren", 64'(bus_a.wr_en), 64'h1);
        check("single_rn0", 64'(bus_a.wr_rn[5:0]), 64'd7);
        check("single_data0", bus_a.wr_data[63:0], 64'hDEAD);
        check("single_rn1", 64'(bus_a.wr_rn[11:6]), 64'h0);
        check("single_data1", bus_a.wr_data[127:64], 64'h0);
        check("single_retire", 64'(bus_a.retire_count), 64'd1);
        @(negedge clk);
        check("single_wren_after", 64'(bus_a.wr_en), 64'h0);

        // rn 0 is discarded: no stall, no write, count unchanged
        set_a(4, 6'd0, 64'h55);
        repeat (3) begin
            @(negedge clk);
            check("rn0_stall", 64'(bus_a.ch_stall), 64'h0);
            check("rn0_wren", 64'(bus_a.wr_en), 64'h0);
            check("rn0_retire", 64'(bus_a.retire_count), 64'd1);
        end
        clear_a();

        // Contention on the single-port instance: one write per cycle in order 0..4
        for (int i = 0; i < 5; i++) set_b(i, 6'(i + 1), 64'h100 + 64'(i));
        @(negedge clk);
        clear_b();
        for (int k = 0; k < 5; k++) begin
            check("cont_stall", 64'(bus_b.ch_stall), 64'((5'h1F << (k + 1)) & 5'h1F));
            @(negedge clk);
            check("cont_wren", 64'(bus_b.wr_en), 64'h1);
            check("cont_rn", 64'(bus_b.wr_rn), 64'(k + 1));
            check("cont_data", bus_b.wr_data, 64'h100 + 64'(k));
        end
        check("cont_retire", 64'(bus_b.retire_count), 64'd5);
        @(negedge clk);
        check("cont_no_dup", 64'(bus_b.wr_en), 64'h0);
        check("cont_retire_hold", 64'(bus_b.retire_count), 64'd5);

        // Same-rn conflict: channel 1 wins, channel 3 waits one cycle
        do_reset();
        set_a(1, 6'd9, 64'hA);
        set_a(3, 6'd9, 64'hB);
        @(negedge clk);
        clear_a();
        check("same_stall", 64'(bus_a.ch_stall), 64'h08);
        @(negedge clk);
        check("same_x_wren", 64'(bus_a.wr_en), 64'h1);
        check("same_x_rn", 64'(bus_a.wr_rn[5:0]), 64'd9);
        check("same_x_data", bus_a.wr_data[63:0], 64'hA);
        @(negedge clk);
        check("same_x1_wren", 64'(bus_a.wr_en), 64'h1);
        check("same_x1_rn", 64'(bus_a.wr_rn[5:0]), 64'd9);
        check("same_x1_data", bus_a.wr_data[63:0], 64'hB);
        @(negedge clk);
        check("same_idle", 64'(bus_a.wr_en), 64'h0);
        check("same_retire", 64'(bus_a.retire_count), 64'd2);

        // Asynchronous reset with three slots full
        do_reset();
        set_a(0, 6'd1, 64'h11);
        set_a(1, 6'd2, 64'h22);
        set_a(2, 6'd3, 64'h33);
        @(negedge clk);
        clear_a();
        set_a(0, 6'd4, 64'h44);
        set_a(1, 6'd5, 64'h55);
        @(negedge clk);
        clear_a();
        check("pre_rst_stall", 64'(bus_a.ch_stall), 64'h02);
        check("pre_rst_wren", 64'(bus_a.wr_en), 64'h3);
        check("pre_rst_retire", 64'(bus_a.retire_count), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_stall", 64'(bus_a.ch_stall), 64'h0);
        check("async_wren", 64'(bus_a.wr_en), 64'h0);
        check("async_wrrn", 64'(bus_a.wr_rn), 64'h0);
        check("async_retire", 64'(bus_a.retire_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_wren", 64'(bus_a.wr_en), 64'h0);
            check("post_rst_retire", 64'(bus_a.retire_count), 64'h0);
        end

        // Saturation from forced near-max count
        do_reset();
        set_a(0, 6'd10, 64'h1010);
        set_a(1, 6'd11, 64'h1111);
        @(negedge clk);
        clear_a();
        set_a(2, 6'd12, 64'h1212);
        force u_dut_a.retire_q = 32'hFFFF_FFFE;
        #1 release u_dut_a.retire_q;
        check("sat_preload", 64'(bus_a.retire_count), 64'hFFFF_FFFE);
        @(negedge clk);
        clear_a();
        check("sat_wren", 64'(bus_a.wr_en), 64'h3);
        check("sat_max", 64'(bus_a.retire_count), 64'hFFFF_FFFF);
        @(negedge clk);
        check("sat_wren2", 64'(bus_a.wr_en), 64'h1);
        check("sat_rn2", 64'(bus_a.wr_rn[5:0]), 64'd12);
        check("sat_hold", 64'(bus_a.retire_count), 64'hFFFF_FFFF);
        @(negedge clk);
        check("sat_hold2", 64'(bus_a.retire_count), 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
